pipe_scroller: RTL
==================

Name: pipe_scroller

Overview:
- Upstream feeder of the collision/game-state stage.
- Owns a ring of NUM_PIPES pipes and scrolls them left once per video frame.
- Respawns each pipe at the right with a pseudo-random gap height.
- Selects the pipe currently in scope for collision checking, and counts pipes passed as the score.
- Also exposes a random-access read port so the VGA renderer can draw every pipe.

Parameters:
NUM_PIPES, 4, pipes in ring (power of 2; index width = log2)
PIPE_SPACING, 160, x distance between consecutive pipe left edges
PIPE_WIDTH, 80, pipe width in pixels
SPEED, 2, pixels moved per Frame_Tick (must be < PIPE_SPACING)
BIRD_X, 160, fixed x of bird left edge
Y_MIN, 60, smallest gap top edge
X_START, 320, initial left edge of pipe 0

Ports:
Clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
Start  in  1  level/pulse; begins run from IDLE
Frame_Tick  in  1  one-cycle pulse per frame; scroll strobe
Lose  in  1  from collision stage; freezes scrolling
Ack  in  1  returns to IDLE from FROZEN
X_Edge  out  10  left edge of in-scope pipe
Y_Edge  out  10  gap top edge of in-scope pipe
Pipe_Index  out  log2(NUM_PIPES)  index of in-scope pipe
Score  out  4  pipes passed, saturating
Pass  out  1  one-cycle pulse when Score would increment
Running  out  1  high in RUN
Rd_Index  in  log2(NUM_PIPES)  renderer read select
Rd_X  out  10  combinational X of pipe Rd_Index
Rd_Y  out  10  combinational Y of pipe Rd_Index

Behaviour:
- Reset state (async, reset_n low):
  - state=IDLE; X[i]=X_START+i*PIPE_SPACING (320,480,640,800); Y[i]=160.
  - cur=0; Score=0; Pass=0; Running=0; LFSR=8'hA5.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Steps every clock in every state, never zero.
- FSM IDLE/RUN/FROZEN (2-bit encoding):
  - IDLE: on Start, go to RUN, reload the X reset layout, set cur=0 and Score=0, and set Y[i]=Y_MIN+rotl(lfsr,i).
  - RUN, Lose=1: go to FROZEN with no movement, even if Frame_Tick is high the same cycle.
  - RUN, Frame_Tick=1 and Lose=0, for each pipe:
    - If X[i] < SPEED: X[i] <= X[i] + NUM_PIPES*PIPE_SPACING - SPEED (respawn) and Y[i] <= Y_MIN + lfsr.
    - Otherwise X[i] <= X[i] - SPEED.
  - RUN, same tick, pass check on the updated value: if X'[cur]+PIPE_WIDTH < BIRD_X, then cur <= cur+1 (mod NUM_PIPES), Pass=1 for the next cycle, Score <= min(Score+1,15).
  - FROZEN: positions, cur and Score held. On Ack go to IDLE. Positions are not reloaded until the next Start.
  - Start while in RUN or FROZEN is ignored. Ack outside FROZEN is ignored. Frame_Tick outside RUN is ignored.
- Only one pipe can respawn per tick and cur advances at most one per tick; this is guaranteed by SPEED < PIPE_SPACING.
- Arithmetic: X and Y are 10-bit unsigned. The respawn sum must not exceed 1023; elaboration-time check NUM_PIPES*PIPE_SPACING ≤ 1023−SPEED. Gap range is Y_MIN..Y_MIN+255.
- Outputs:
  - X_Edge, Y_Edge, Rd_X and Rd_Y are combinational muxes of registers, so new values are visible the cycle after the tick edge.
  - Pass, Score, Pipe_Index and Running are registered.
- reset_n asserted mid-run: immediate return to reset values; no Pass pulse is produced.

Decomposition:
- flappy_pkg: screen constants (640x480), PIPE_WIDTH, GAP_HEIGHT=100 (shared with the collision stage), BIRD_X, Y_MIN, FSM state encodings, and the LFSR seed/taps.
- One sub-module, pipe_lfsr: 8-bit free-running LFSR with async active-low reset and seed parameter.
- The pipe register array and the FSM stay in pipe_scroller.

Test Plan:
1. Reset, then release with no Start → X_Edge=320, Y_Edge=160, Pipe_Index=0, Score=0, Running=0. 100 Frame_Ticks cause no change.
2. Start, then 1 Frame_Tick → X_Edge=318, Running=1. Rd_Index=3 gives Rd_X=798.
3. Start, then 121 ticks → on tick 121 X[0]=78 (78+80<160): Pass one cycle, Score=1, Pipe_Index=1, X_Edge=238. Tick 120 gives no Pass.
4. Continue to tick 161 → X[0] goes from 0 to 638 and Rd_Y[0]=Y_MIN+lfsr sampled that cycle. Check the LFSR sequence against a reference model from seed 8'hA5.
5. Lose and Frame_Tick asserted in the same cycle in RUN → X unchanged, state FROZEN. Ticks are ignored. Ack → IDLE. Next Start reloads 320 and clears Score.
6. Run until 16 passes → Score holds 15 while Pass still pulses. Asserting reset_n low mid-tick restores all reset values asynchronously.

Source files
------------

// File: rtl/flappy_pkg.sv
// Shared constants for the flappy pipeline: screen geometry, pipe/bird
// geometry, scroller FSM encoding and the gap-height LFSR seed/taps.
package flappy_pkg;

  localparam int C_SCREEN_W   = 640;
  localparam int C_SCREEN_H   = 480;
  localparam int C_PIPE_WIDTH = 80;
  localparam int C_GAP_HEIGHT = 100;
  localparam int C_BIRD_X     = 160;
  localparam int C_Y_MIN      = 60;

  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [7:0] C_LFSR_SEED = 8'hA5;
  localparam logic [7:0] C_LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } scroll_state_t;

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < 8; k++)
      if (k < int'(n % 8)) r = {r[6:0], r[7]};
    return r;
  endfunction

endpackage

// File: rtl/pipe_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; a non-zero seed keeps it off the
// all-zero lock-up state.
module pipe_lfsr
  import flappy_pkg::*;
#(
  parameter logic [7:0] SEED = C_LFSR_SEED,
  parameter logic [7:0] TAPS = C_LFSR_TAPS
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  output logic [7:0] o_lfsr
);

  logic [7:0] r_lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= SEED;
    else          r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & TAPS)};
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/pipe_scroller.sv
// Ring of pipes scrolled left once per frame, respawned at the right with a
// random gap; tracks the in-scope pipe for collision and counts passes.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES    = 4,
  parameter int PIPE_SPACING = 160,
  parameter int PIPE_WIDTH   = C_PIPE_WIDTH,
  parameter int SPEED        = 2,
  parameter int BIRD_X       = C_BIRD_X,
  parameter int Y_MIN        = C_Y_MIN,
  parameter int X_START      = 320,
  localparam int IW          = $clog2(NUM_PIPES)
) (
  input  logic          Clk,
  input  logic          reset_n,
  input  logic          Start,
  input  logic          Frame_Tick,
  input  logic          Lose,
  input  logic          Ack,
  output logic [9:0]    X_Edge,
  output logic [9:0]    Y_Edge,
  output logic [IW-1:0] Pipe_Index,
  output logic [3:0]    Score,
  output logic          Pass,
  output logic          Running,
  input  logic [IW-1:0] Rd_Index,
  output logic [9:0]    Rd_X,
  output logic [9:0]    Rd_Y
);

  localparam logic [9:0]  SPD10    = 10'(SPEED);
  localparam logic [9:0]  YMIN10   = 10'(Y_MIN);
  localparam logic [9:0]  RESPAWN  = 10'(NUM_PIPES * PIPE_SPACING - SPEED);
  localparam logic [10:0] PW11     = 11'(PIPE_WIDTH);
  localparam logic [10:0] BIRD11   = 11'(BIRD_X);
  localparam logic [9:0]  Y_RESET  = 10'd160;

  if (NUM_PIPES * PIPE_SPACING > 1023 - SPEED) begin : g_bad_range
    $error("pipe_scroller: respawn position overflows 10 bits");
  end
  if (SPEED >= PIPE_SPACING) begin : g_bad_speed
    $error("pipe_scroller: SPEED must be below PIPE_SPACING");
  end

  scroll_state_t r_state, w_state_nxt;
  logic [NUM_PIPES-1:0][9:0] r_x, r_y, w_x_step, w_y_step, w_x_init, w_y_init;
  logic [NUM_PIPES-1:0]      w_resp;
  logic [7:0]                w_lfsr;
  logic [IW-1:0]             r_cur;
  logic [3:0]                r_score;
  logic                      r_pass, r_running;
  logic                      w_start, w_tick, w_passed;

  pipe_lfsr #(.SEED(C_LFSR_SEED), .TAPS(C_LFSR_TAPS)) u_lfsr (
    .i_clk  (Clk),
    .i_rst_n(reset_n),
    .o_lfsr (w_lfsr)
  );

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
    assign w_x_init[g] = 10'(X_START + g * PIPE_SPACING);
    assign w_y_init[g] = YMIN10 + {2'b00, rotl8(w_lfsr, g)};
    assign w_resp[g]   = r_x[g] < SPD10;
    assign w_x_step[g] = w_resp[g] ? r_x[g] + RESPAWN : r_x[g] - SPD10;
    assign w_y_step[g] = w_resp[g] ? YMIN10 + {2'b00, w_lfsr} : r_y[g];
  end

  assign w_start = (r_state == ST_IDLE) && Start;
  // Lose wins over a coincident tick so the frozen frame matches the hit
  assign w_tick   = (r_state == ST_RUN) && Frame_Tick && !Lose;
  assign w_passed = w_tick && (({1'b0, w_x_step[r_cur]} + PW11) < BIRD11);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (Start) w_state_nxt = ST_RUN;
      ST_RUN:    if (Lose)  w_state_nxt = ST_FROZEN;
      ST_FROZEN: if (Ack)   w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cur     <= '0;
      r_score   <= '0;
      r_pass    <= 1'b0;
      r_running <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_x[i] <= 10'(X_START + i * PIPE_SPACING);
        r_y[i] <= Y_RESET;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == ST_RUN);
      r_pass    <= w_passed;
      if (w_start) begin
        r_x     <= w_x_init;
        r_y     <= w_y_init;
        r_cur   <= '0;
        r_score <= '0;
      end else if (w_tick) begin
        r_x <= w_x_step;
        r_y <= w_y_step;
        if (w_passed) begin
          r_cur   <= r_cur + 1'b1;
          r_score <= (r_score == 4'd15) ? r_score : r_score + 4'd1;
        end
      end
    end
  end

  assign X_Edge     = r_x[r_cur];
  assign Y_Edge     = r_y[r_cur];
  assign Rd_X       = r_x[Rd_Index];
  assign Rd_Y       = r_y[Rd_Index];
  assign Pipe_Index = r_cur;
  assign Score      = r_score;
  assign Pass       = r_pass;
  assign Running    = r_running;

endmodule
